irq_port_ctrl: RTL and testbench
================================

# irq_port_ctrl

Input-side conditioning block that sits directly upstream of `CPU_WrapperV3` and drives its `int_sig` and `I_Port` inputs. It does four things:
- synchronises the asynchronous external interrupt line and input bus;
- debounces the interrupt line;
- counts accepted interrupt events in a saturating pending counter;
- holds `int_sig` high until the CPU acknowledges, then enforces a guard gap so each request is seen as a fresh edge.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the synchronisers for both `irq_in` and `in_raw`. Minimum 2.
- `DEBOUNCE`, default 4: number of consecutive synchronised-high cycles required to accept an interrupt. Range 1..15.
- `GAP_CYCLES`, default 2: forced `int_sig`-low cycles after each acknowledge. Range 1..7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `irq_in` in 1: external interrupt request, asynchronous, active high.
- `in_raw` in 8: external input bus, asynchronous.
- `int_en` in 1: global interrupt enable.
- `int_ack` in 1: CPU acknowledge, a one-cycle pulse when the CPU takes the interrupt.
- `ovf_clr` in 1: clears the sticky overflow flag.
- `int_sig` out 1: interrupt request to the CPU, level signal.
- `I_Port` out 8: synchronised input bus to the CPU.
- `pend_cnt` out 2: number of accepted, unacknowledged events (0..3).
- `ovf` out 1: sticky flag, set when an event arrives while `pend_cnt` == 3.

## Operation
- **Reset (`rstn`=0):** all synchroniser flops, the debounce counter, `pend_cnt`, `ovf`, `I_Port` and `int_sig` go to 0; the FSM goes to IDLE. Assertion takes effect immediately, including mid-request. After release, any `irq_in` that is still high needs a full debounce before it counts.
- **Input bus:** `in_raw` passes through `SYNC_STAGES` flops and appears on `I_Port`. There is no other processing.
- **Debounce:**
  - A 4-bit counter `dcnt` increments on each edge where the synchronised irq is 1.
  - It resets to 0 on each edge where the synchronised irq is 0.
  - It saturates at `DEBOUNCE`.
  - An event fires on the single edge where `dcnt` transitions from `DEBOUNCE`-1 to `DEBOUNCE`. That gives one event per high period, however long the period is.
- **Pending counter, updated each edge:**
  - Event only: `pend_cnt`+1. If `pend_cnt` is already 3, it stays 3 and `ovf` is set.
  - Valid ack only: `pend_cnt`-1.
  - Event and valid ack together: `pend_cnt` unchanged. `ovf` is not set.
  - A valid ack is `int_ack`=1 while the FSM is in REQ. An ack in any other state is ignored.
  - `ovf_clr` clears `ovf`. If `ovf_clr` and an overflow event occur on the same edge, `ovf` stays 1 (set wins).
  - Events are counted regardless of `int_en`.
- **FSM (IDLE, REQ, GAP):**
  - IDLE: `int_sig`=0. Go to REQ when `pend_cnt`!=0 and `int_en`=1.
  - REQ: `int_sig`=1.
    - On a valid ack, go to GAP and load the gap counter with `GAP_CYCLES`.
    - If `int_en`=0, go to IDLE with `pend_cnt` kept.
    - If both occur on the same edge, the ack wins and the FSM goes to GAP.
  - GAP: `int_sig`=0. The gap counter decrements each edge. At 0, go to IDLE; IDLE then re-requests if `pend_cnt`!=0.
- `int_sig` is a registered output decoded from the state register. It never glitches.

## Timing
- Edge numbering: E0 is the first edge that samples `irq_in`=1 into synchroniser stage 1.
- The synchronised irq is 1 after E(`SYNC_STAGES`-1).
- The event fires and `pend_cnt` increments at E(`SYNC_STAGES`-1+`DEBOUNCE`).
- `int_sig` rises at E(`SYNC_STAGES`+`DEBOUNCE`). With defaults this is E6.
- An `irq_in` pulse shorter than `DEBOUNCE` synchronised cycles produces no event.
- Ack in REQ at edge A:
  - `int_sig` falls at A.
  - `pend_cnt` decrements at A.
  - The earliest re-assertion is A+`GAP_CYCLES`+1.
- `I_Port` latency is `SYNC_STAGES` edges from first sampling.

## Test plan
1. Reset, then hold `irq_in`=1 with `int_en`=1. Required: `int_sig` rises exactly at E6 and `pend_cnt`=1. Then pulse `int_ack` for one cycle at A. Required: `int_sig`=0 and `pend_cnt`=0 at A, and `int_sig` stays low thereafter.
2. Apply `irq_in` high pulses of 3 cycles and of 4 cycles (defaults). Required: the 3-cycle pulse gives `pend_cnt`=0; the 4-cycle pulse gives exactly 1 event. A 50-cycle high period gives only 1 event.
3. Apply 4 debounced events with no ack. Required: `pend_cnt` saturates at 3 and `ovf`=1. Assert `ovf_clr`. Required: `ovf`=0. Then give 3 acks, each separated by a gap. Required: three `int_sig` assertions, each preceded by at least 2 low cycles, ending with `pend_cnt`=0.
4. Hold `int_en`=0 and apply 2 events. Required: `int_sig` stays 0 and `pend_cnt`=2. Set `int_en`=1. Required: REQ on the next edge. Drop `int_en` while in REQ without an ack. Required: IDLE with `pend_cnt` still 2.
5. Align the event edge with a valid ack while `pend_cnt`=1. Required: `pend_cnt` stays 1 and the FSM goes to GAP, then back to REQ.
6. Drive `in_raw` 0x00→0xA5. Required: `I_Port`=0xA5 two edges later. Assert `rstn`=0 while in REQ. Required: immediately `int_sig`=0, `pend_cnt`=0, `I_Port`=0x00.

Source files
------------

// File: rtl/irq_port_ctrl.sv
// irq_port_ctrl: conditions the asynchronous interrupt line and input bus
// for the CPU. Synchronises both, debounces the interrupt, counts accepted
// events in a saturating pending counter (with sticky overflow), and drives
// a level int_sig that drops on acknowledge and stays low for a guard gap so
// every request reaches the CPU as a fresh rising edge.
module irq_port_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       irq_in,
  input  logic [7:0] in_raw,
  input  logic       int_en,
  input  logic       int_ack,
  input  logic       ovf_clr,
  output logic       int_sig,
  output logic [7:0] I_Port,
  output logic [1:0] pend_cnt,
  output logic       ovf
);

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE);
  localparam logic [2:0] GAP_LOAD  = 3'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Stage 0 is the first capture flop; stage SYNC_STAGES-1 is the safe output.
  logic [SYNC_STAGES-1:0]       irq_sync_q, irq_sync_d;
  logic [SYNC_STAGES-1:0][7:0]  in_sync_q, in_sync_d;
  logic [3:0]                   dcnt_q, dcnt_d;
  logic [1:0]                   pend_q, pend_d;
  logic                         ovf_q, ovf_d;
  state_t                       state_q, state_d;
  logic [2:0]                   gap_q, gap_d;
  logic                         int_sig_q, int_sig_d;

  logic irq_s;
  logic event_s;
  logic valid_ack_s;
  logic ovf_set_s;

  assign irq_s       = irq_sync_q[SYNC_STAGES-1];
  assign valid_ack_s = int_ack & (state_q == ST_REQ);

  // Shift both synchroniser chains by one stage per clock.
  always_comb begin
    irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], irq_in};
    in_sync_d  = {in_sync_q[SYNC_STAGES-2:0], in_raw};
  end

  // Debounce: count consecutive synchronised-high cycles, fire once on reaching the limit.
  always_comb begin
    dcnt_d  = dcnt_q;
    event_s = 1'b0;
    if (irq_s) begin
      if (dcnt_q != DEB_LIMIT) begin
        dcnt_d = dcnt_q + 4'd1;
      end else begin
        dcnt_d = dcnt_q;
      end
      event_s = (dcnt_q == (DEB_LIMIT - 4'd1));
    end else begin
      dcnt_d = 4'd0;
    end
  end

  // Pending counter and sticky overflow; a simultaneous event and ack cancel out.
  always_comb begin
    pend_d    = pend_q;
    ovf_set_s = 1'b0;
    if (event_s && !valid_ack_s) begin
      if (pend_q == 2'd3) begin
        pend_d    = pend_q;
        ovf_set_s = 1'b1;
      end else begin
        pend_d = pend_q + 2'd1;
      end
    end else if (valid_ack_s && !event_s) begin
      if (pend_q != 2'd0) begin
        pend_d = pend_q - 2'd1;
      end else begin
        pend_d = pend_q;
      end
    end else begin
      pend_d = pend_q;
    end

    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Request FSM next state; the ack takes priority over a dropped enable in REQ.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        gap_d = 3'd0;
        if ((pend_q != 2'd0) && int_en) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (valid_ack_s) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (!int_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_GAP: begin
        if (gap_q <= 3'd1) begin
          state_d = ST_IDLE;
          gap_d   = 3'd0;
        end else begin
          state_d = ST_GAP;
          gap_d   = gap_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so int_sig is a clean flop output.
  always_comb begin
    int_sig_d = (state_d == ST_REQ);
  end

  // Datapath flops: synchronisers, debounce counter, pending counter, overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_sync_q <= '0;
      in_sync_q  <= '0;
      dcnt_q     <= 4'd0;
      pend_q     <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      irq_sync_q <= irq_sync_d;
      in_sync_q  <= in_sync_d;
      dcnt_q     <= dcnt_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  // FSM state register, gap counter and registered request output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gap_q     <= 3'd0;
      int_sig_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      int_sig_q <= int_sig_d;
    end
  end

  assign int_sig  = int_sig_q;
  assign I_Port   = in_sync_q[SYNC_STAGES-1];
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_port_ctrl.sv
// Self-checking bench for irq_port_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model (delay lines, run length, integer pending count, and a
// request flag with the time of the last acknowledge).
module tb_irq_port_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       irq_in = 1'b0;
  logic [7:0] in_raw = 8'h00;
  logic       int_en = 1'b0;
  logic       int_ack = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       int_sig;
  logic [7:0] I_Port;
  logic [1:0] pend_cnt;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic       m_irq_dl [SYNC];
  logic [7:0] m_raw_dl [SYNC];
  int         m_run;
  int         m_pend;
  bit         m_ovf;
  bit         m_req;
  int         m_cyc = 0;
  int         m_last_ack;

  irq_port_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rstn(rstn), .irq_in(irq_in), .in_raw(in_raw),
    .int_en(int_en), .int_ack(int_ack), .ovf_clr(ovf_clr),
    .int_sig(int_sig), .I_Port(I_Port), .pend_cnt(pend_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) begin
      m_irq_dl[i] = 1'b0;
      m_raw_dl[i] = 8'h00;
    end
    m_run = 0;
    m_pend = 0;
    m_ovf = 1'b0;
    m_req = 1'b0;
    m_last_ack = -100;
  endtask

  // One clock edge of the model, using the inputs as the edge sees them.
  task automatic model_update();
    bit s;
    bit ev;
    bit ack;
    int p;
    if (!rstn) begin
      model_reset();
    end else begin
      s = m_irq_dl[SYNC-1];
      m_run = s ? m_run + 1 : 0;
      ev = (m_run == DEB);
      ack = int_ack && m_req;
      p = m_pend;
      if (ev && !ack) begin
        if (p < 3) m_pend = p + 1;
      end else if (ack && !ev) begin
        m_pend = p - 1;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (ev && !ack && p == 3) m_ovf = 1'b1;
      if (m_req) begin
        if (ack) begin
          m_req = 1'b0;
          m_last_ack = m_cyc;
        end else if (!int_en) begin
          m_req = 1'b0;
        end
      end else if ((m_cyc - m_last_ack) > GAP && p != 0 && int_en) begin
        m_req = 1'b1;
      end
      for (int i = SYNC - 1; i > 0; i--) begin
        m_irq_dl[i] = m_irq_dl[i-1];
        m_raw_dl[i] = m_raw_dl[i-1];
      end
      m_irq_dl[0] = irq_in;
      m_raw_dl[0] = in_raw;
    end
    m_cyc++;
  endtask

  // Advance one clock: update the model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("int_sig", int'(int_sig), int'(m_req));
    chk("pend_cnt", int'(pend_cnt), m_pend);
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("I_Port", int'(I_Port), int'(m_raw_dl[SYNC-1]));
  endtask

  task automatic pulse(input int hi, input int lo);
    irq_in = 1'b1;
    repeat (hi) step();
    irq_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic wait_int(input int max, output int lows);
    lows = 0;
    while (int_sig !== 1'b1 && lows < max) begin
      step();
      lows++;
    end
    chk("wait_int_sig", int'(int_sig), 1);
  endtask

  task automatic do_ack(output int lows);
    wait_int(40, lows);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  initial begin
    int l;
    model_reset();
    @(negedge clk);
    step();
    chk("reset_int_sig", int'(int_sig), 0);
    chk("reset_pend", int'(pend_cnt), 0);
    chk("reset_ovf", int'(ovf), 0);
    rstn = 1'b1;
    step();

    // 1: int_sig rises exactly at E6, ack clears it
    int_en = 1'b1;
    irq_in = 1'b1;
    repeat (6) step();
    chk("t1_int_sig_E5", int'(int_sig), 0);
    chk("t1_pend_E5", int'(pend_cnt), 1);
    step();
    chk("t1_int_sig_E6", int'(int_sig), 1);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t1_int_sig_A", int'(int_sig), 0);
    chk("t1_pend_A", int'(pend_cnt), 0);
    repeat (10) step();
    chk("t1_int_sig_after", int'(int_sig), 0);
    irq_in = 1'b0;
    repeat (4) step();

    // 2: short pulse rejected, minimum pulse and long pulse give one event
    pulse(3, 8);
    chk("t2_short_pend", int'(pend_cnt), 0);
    pulse(4, 4);
    chk("t2_min_pend", int'(pend_cnt), 1);
    do_ack(l);
    pulse(50, 6);
    chk("t2_long_pend", int'(pend_cnt), 1);
    do_ack(l);
    repeat (4) step();
    chk("t2_end_pend", int'(pend_cnt), 0);

    // 3: saturation, overflow, clear, three separated requests
    repeat (4) pulse(6, 4);
    chk("t3_pend_sat", int'(pend_cnt), 3);
    chk("t3_ovf_set", int'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", int'(ovf), 0);
    do_ack(l);
    do_ack(l);
    chk("t3_gap2_lows", l, GAP + 1);
    do_ack(l);
    chk("t3_gap3_lows", l, GAP + 1);
    repeat (4) step();
    chk("t3_pend_end", int'(pend_cnt), 0);
    chk("t3_int_sig_end", int'(int_sig), 0);

    // 4: events counted while disabled; enable/disable behaviour
    int_en = 1'b0;
    pulse(6, 4);
    pulse(6, 4);
    chk("t4_int_sig_dis", int'(int_sig), 0);
    chk("t4_pend_dis", int'(pend_cnt), 2);
    int_en = 1'b1;
    step();
    chk("t4_req_on_en", int'(int_sig), 1);
    int_en = 1'b0;
    step();
    chk("t4_idle_on_dis", int'(int_sig), 0);
    chk("t4_pend_kept", int'(pend_cnt), 2);
    int_en = 1'b1;
    do_ack(l);
    do_ack(l);
    repeat (4) step();
    chk("t4_pend_end", int'(pend_cnt), 0);

    // 5: event and valid ack on the same edge
    pulse(6, 4);
    chk("t5_pend_pre", int'(pend_cnt), 1);
    irq_in = 1'b1;
    repeat (5) step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t5_pend_same", int'(pend_cnt), 1);
    chk("t5_int_sig_gap", int'(int_sig), 0);
    repeat (2) step();
    chk("t5_int_sig_gap2", int'(int_sig), 0);
    step();
    chk("t5_int_sig_rereq", int'(int_sig), 1);
    irq_in = 1'b0;
    do_ack(l);
    repeat (4) step();

    // 6: input bus latency and asynchronous reset during a request
    in_raw = 8'h00;
    repeat (3) step();
    in_raw = 8'hA5;
    step();
    chk("t6_iport_1edge", int'(I_Port), 8'h00);
    step();
    chk("t6_iport_2edge", int'(I_Port), 8'hA5);
    pulse(6, 2);
    chk("t6_in_req", int'(int_sig), 1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_int_sig", int'(int_sig), 0);
    chk("t6_rst_pend", int'(pend_cnt), 0);
    chk("t6_rst_iport", int'(I_Port), 8'h00);
    model_reset();
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0) irq_in = ~irq_in;
      if ($urandom % 40 == 0) int_en = ~int_en;
      int_ack = ($urandom % 5 == 0);
      ovf_clr = ($urandom % 25 == 0);
      in_raw = 8'($urandom);
      rstn = ($urandom % 400 != 0);
      step();
    end
    rstn = 1'b1;
    int_ack = 1'b0;
    ovf_clr = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
